// File: rtl/mesh_pkg.sv
// Shared types and helpers for the mesh_gnrtr router output-port logic.
// Field offsets are counted from the packet MSB so they hold for any packet width.
package mesh_pkg;

  // Output directions of a mesh router node.
  typedef enum logic [2:0] {
    N     = 3'd0,
    S     = 3'd1,
    E     = 3'd2,
    W     = 3'd3,
    LOCAL = 3'd4
  } dir_e;

  // Output-port scheduler states: arbitrate, pop the winner, hold it downstream.
  typedef enum logic [1:0] {
    ARB  = 2'd0,
    POP  = 2'd1,
    HOLD = 2'd2
  } sched_state_e;

  localparam int NXT_JUMP_W = 8;
  localparam int ID_W       = 4;

  // MSB of each field sits at pckg_sz - <OFS>.
  localparam int NXT_JUMP_OFS = 1;
  localparam int TROW_OFS     = 9;
  localparam int TCOL_OFS     = 13;
  localparam int MODE_OFS     = 17;

  // Dimension-ordered next hop: mode=1 resolves the row first, mode=0 the column first.
  function automatic dir_e route_dir(input logic [ID_W-1:0] trow,
                                     input logic [ID_W-1:0] tcol,
                                     input logic            mode,
                                     input logic [ID_W-1:0] id_row,
                                     input logic [ID_W-1:0] id_column);
    dir_e d;
    if (mode) begin
      if (trow != id_row)         d = (trow < id_row) ? N : S;
      else if (tcol != id_column) d = (tcol < id_column) ? W : E;
      else                        d = LOCAL;
    end else begin
      if (tcol != id_column)      d = (tcol < id_column) ? W : E;
      else if (trow != id_row)    d = (trow < id_row) ? N : S;
      else                        d = LOCAL;
    end
    return d;
  endfunction

endpackage

// File: rtl/mesh_out_port_sched_rr_arbiter.sv
// Combinational round-robin picker: the first requester above the pointer wins.
module rr_arbiter #(
  parameter int N_IN  = 4,
  parameter int PTR_W = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic [N_IN-1:0]  i_req,
  input  logic [PTR_W-1:0] i_rr_ptr,
  output logic [N_IN-1:0]  o_grant,
  output logic             o_valid
);

  // Scan upward from i_rr_ptr+1, wrapping, and keep only the first request found.
  always_comb begin : pick
    logic [PTR_W-1:0] w_idx;
    o_grant = '0;
    o_valid = 1'b0;
    w_idx   = '0;
    for (int k = 1; k <= N_IN; k++) begin
      w_idx = PTR_W'((int'(i_rr_ptr) + k) % N_IN);
      if (!o_valid && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        o_valid        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mesh_out_port_sched.sv
// Output-port scheduler for one direction of a mesh router node: routes each
// FIFO head, round-robins among those aimed at this port and holds the winner.
module mesh_out_port_sched
  import mesh_pkg::*;
#(
  parameter int pckg_sz   = 40,
  parameter int N_IN      = 4,
  parameter int OUT_DIR   = 0,
  parameter int id_row    = 0,
  parameter int id_column = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_IN-1:0]         in_pndng,
  input  logic [N_IN*pckg_sz-1:0] in_data,
  output logic [N_IN-1:0]         in_pop,
  output logic                    out_pndng,
  output logic [pckg_sz-1:0]      out_data,
  input  logic                    out_pop
);

  localparam int PTR_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [ID_W-1:0] ID_ROW_L = ID_W'(id_row);
  localparam logic [ID_W-1:0] ID_COL_L = ID_W'(id_column);
  localparam dir_e OUT_DIR_E = dir_e'(3'(OUT_DIR));

  sched_state_e         r_state;
  logic [PTR_W-1:0]     r_rr_ptr;
  logic [N_IN-1:0]      r_grant;
  logic [N_IN-1:0]      r_in_pop;
  logic                 r_out_pndng;
  logic [pckg_sz-1:0]   r_out_data;

  logic [N_IN-1:0]      w_match;
  logic [N_IN-1:0]      w_grant;
  logic                 w_grant_valid;
  logic [PTR_W-1:0]     w_grant_idx;
  logic [pckg_sz-1:0]   w_sel_data;
  logic [pckg_sz-1:0]   w_cap_data;

  // A head competes for this port only when it is valid and routes here.
  always_comb begin
    w_match = '0;
    for (int i = 0; i < N_IN; i++) begin
      w_match[i] = in_pndng[i] &
                   (route_dir(in_data[i*pckg_sz + pckg_sz - TROW_OFS -: ID_W],
                              in_data[i*pckg_sz + pckg_sz - TCOL_OFS -: ID_W],
                              in_data[i*pckg_sz + pckg_sz - MODE_OFS],
                              ID_ROW_L, ID_COL_L) == OUT_DIR_E);
    end
  end

  rr_arbiter #(
    .N_IN  (N_IN),
    .PTR_W (PTR_W)
  ) u_arb (
    .i_req    (w_match),
    .i_rr_ptr (r_rr_ptr),
    .o_grant  (w_grant),
    .o_valid  (w_grant_valid)
  );

  // Convert the registered one-hot grant to an index for data select and pointer update.
  always_comb begin
    w_grant_idx = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (r_grant[i]) w_grant_idx = PTR_W'(i);
    end
  end

  assign w_sel_data = in_data[w_grant_idx*pckg_sz +: pckg_sz];
  assign w_cap_data = {ID_ROW_L, ID_COL_L, w_sel_data[pckg_sz-NXT_JUMP_W-1:0]};

  // Scheduler FSM with the one-entry output register; every output is registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ARB;
      r_rr_ptr    <= PTR_W'(N_IN - 1);
      r_grant     <= '0;
      r_in_pop    <= '0;
      r_out_pndng <= 1'b0;
      r_out_data  <= '0;
    end else begin
      case (r_state)
        ARB: begin
          if (w_grant_valid) begin
            r_grant  <= w_grant;
            r_in_pop <= w_grant;
            r_state  <= POP;
          end
        end
        POP: begin
          r_in_pop    <= '0;
          r_out_data  <= w_cap_data;
          r_out_pndng <= 1'b1;
          r_rr_ptr    <= w_grant_idx;
          r_state     <= HOLD;
        end
        HOLD: begin
          if (out_pop) begin
            r_out_pndng <= 1'b0;
            r_state     <= ARB;
          end
        end
        default: begin
          r_in_pop <= '0;
          r_state  <= ARB;
        end
      endcase
    end
  end

  // A pop pending when reset arrives is suppressed in that same cycle.
  assign in_pop    = r_in_pop & {N_IN{~reset}};
  assign out_pndng = r_out_pndng;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_mesh_out_port_sched.sv
// Directed bench for mesh_out_port_sched at node (1,1): S, E and LOCAL port
// instances share the same input heads.
module tb_mesh_out_port_sched;

  localparam int PSZ = 40;
  localparam int NIN = 4;

  logic             clock;
  logic             reset;
  logic [NIN-1:0]   inPndng;
  logic [NIN*PSZ-1:0] inData;
  logic [NIN-1:0]   inPopS, inPopE, inPopL;
  logic             outPndngS, outPndngE, outPndngL;
  logic [PSZ-1:0]   outDataS, outDataE, outDataL;
  logic             outPopS, outPopE, outPopL;

  int checkCount = 0;
  int passCount  = 0;
  logic monitorOn = 1'b0;

  typedef struct {
    string      name;
    logic [3:0] trow;
    logic [3:0] tcol;
    logic       mode;
    logic       expS;
    logic       expE;
    logic       expL;
  } vec_t;

  vec_t vecs[$];

  mesh_out_port_sched #(.pckg_sz(PSZ), .N_IN(NIN), .OUT_DIR(1), .id_row(1), .id_column(1)) dutS (
    .clk(clock), .reset(reset), .in_pndng(inPndng), .in_data(inData),
    .in_pop(inPopS), .out_pndng(outPndngS), .out_data(outDataS), .out_pop(outPopS));

  mesh_out_port_sched #(.pckg_sz(PSZ), .N_IN(NIN), .OUT_DIR(2), .id_row(1), .id_column(1)) dutE (
    .clk(clock), .reset(reset), .in_pndng(inPndng), .in_data(inData),
    .in_pop(inPopE), .out_pndng(outPndngE), .out_data(outDataE), .out_pop(outPopE));

  mesh_out_port_sched #(.pckg_sz(PSZ), .N_IN(NIN), .OUT_DIR(4), .id_row(1), .id_column(1)) dutL (
    .clk(clock), .reset(reset), .in_pndng(inPndng), .in_data(inData),
    .in_pop(inPopL), .out_pndng(outPndngL), .out_data(outDataL), .out_pop(outPopL));

  // 10 ns clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [PSZ-1:0] mkPkt(input logic [7:0] nj, input logic [3:0] r,
                                           input logic [3:0] c, input logic m,
                                           input logic [22:0] pl);
    return {nj, r, c, m, pl};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic [NIN-1:0] p, input logic [PSZ-1:0] d0,
                               input logic [PSZ-1:0] d1, input logic [PSZ-1:0] d2,
                               input logic [PSZ-1:0] d3);
    inPndng = p;
    inData  = {d3, d2, d1, d0};
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic addVec(input string n, input logic [3:0] r, input logic [3:0] c,
                        input logic m, input logic es, input logic ee, input logic el);
    vec_t v;
    v.name = n; v.trow = r; v.tcol = c; v.mode = m;
    v.expS = es; v.expE = ee; v.expL = el;
    vecs.push_back(v);
  endtask

  // Continuous invariants on the S port: pop is one-hot or zero and never overlaps a held packet.
  always @(negedge clock) begin
    if (monitorOn) begin
      checkOutput("pop_onehot_s", {63'b0, $onehot0(inPopS)}, 64'd1);
      checkOutput("pop_while_pndng_s", {63'b0, (|inPopS) & outPndngS}, 64'd0);
    end
  end

  // A head must stay pending through the cycle it is popped.
  always @(posedge clock) begin
    if (monitorOn && !reset)
      assert (((inPopS | inPopE | inPopL) & ~inPndng) == '0)
        else $error("[TB] in_pndng dropped during pop");
  end

  initial begin
    logic [PSZ-1:0] z;
    logic [PSZ-1:0] hold;
    int bad;
    z = '0;
    reset = 1'b1;
    outPopS = 1'b0; outPopE = 1'b0; outPopL = 1'b0;
    applyStimulus(4'b0000, z, z, z, z);
    tick();
    tick();

    // Reset state
    checkOutput("reset_in_pop", inPopS, 0);
    checkOutput("reset_out_pndng", outPndngS, 0);
    checkOutput("reset_out_data", outDataS, 0);
    monitorOn = 1'b1;

    // Route table at node (1,1): one head on input 0, see which port pops it
    addVec("r2c2_m1", 4'd2, 4'd2, 1'b1, 1, 0, 0);
    addVec("r2c2_m0", 4'd2, 4'd2, 1'b0, 0, 1, 0);
    addVec("r1c1_m1", 4'd1, 4'd1, 1'b1, 0, 0, 1);
    addVec("r1c1_m0", 4'd1, 4'd1, 1'b0, 0, 0, 1);
    addVec("r0c1_m1", 4'd0, 4'd1, 1'b1, 0, 0, 0);
    addVec("r3c1_m1", 4'd3, 4'd1, 1'b1, 1, 0, 0);
    addVec("r1c2_m1", 4'd1, 4'd2, 1'b1, 0, 1, 0);
    addVec("r1c0_m0", 4'd1, 4'd0, 1'b0, 0, 0, 0);
    addVec("r0c2_m0", 4'd0, 4'd2, 1'b0, 0, 1, 0);
    addVec("r0c2_m1", 4'd0, 4'd2, 1'b1, 0, 0, 0);
    addVec("r3c1_m0", 4'd3, 4'd1, 1'b0, 1, 0, 0);
    addVec("r1c3_m0", 4'd1, 4'd3, 1'b0, 0, 1, 0);
    addVec("rFcF_m1", 4'd15, 4'd15, 1'b1, 1, 0, 0);
    addVec("r2c0_m0", 4'd2, 4'd0, 1'b0, 0, 0, 0);
    addVec("r2c0_m1", 4'd2, 4'd0, 1'b1, 1, 0, 0);

    foreach (vecs[i]) begin
      reset = 1'b1;
      tick();
      reset = 1'b0;
      applyStimulus(4'b0001, mkPkt(8'h00, vecs[i].trow, vecs[i].tcol, vecs[i].mode, 23'h5A5A5), z, z, z);
      tick();
      checkOutput({vecs[i].name, "_popS"}, inPopS, {3'b0, vecs[i].expS});
      checkOutput({vecs[i].name, "_popE"}, inPopE, {3'b0, vecs[i].expE});
      checkOutput({vecs[i].name, "_popL"}, inPopL, {3'b0, vecs[i].expL});
    end

    // Single packet on input 2 routed south, latency and nxt_jump rewrite
    reset = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(4'b0100, z, z, mkPkt(8'hAB, 4'd3, 4'd1, 1'b1, 23'h001234), z);
    checkOutput("single_t0_pop", inPopS, 0);
    tick();
    checkOutput("single_t1_pop", inPopS, 4'b0100);
    checkOutput("single_t1_pndng", outPndngS, 0);
    checkOutput("single_t1_popE", inPopE, 0);
    tick();
    checkOutput("single_t2_pop", inPopS, 0);
    checkOutput("single_t2_pndng", outPndngS, 1);
    checkOutput("single_t2_data", outDataS, mkPkt(8'h11, 4'd3, 4'd1, 1'b1, 23'h001234));
    applyStimulus(4'b0000, z, z, z, z);
    outPopS = 1'b1;
    tick();
    checkOutput("single_drained", outPndngS, 0);
    outPopS = 1'b0;

    // Non-matching traffic: every head heads north
    reset = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(4'b1111, mkPkt(8'h0, 4'd0, 4'd0, 1'b1, 23'd0), mkPkt(8'h0, 4'd0, 4'd1, 1'b1, 23'd1),
                  mkPkt(8'h0, 4'd0, 4'd2, 1'b1, 23'd2), mkPkt(8'h0, 4'd0, 4'd3, 1'b1, 23'd3));
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if ((|inPopS) || (|inPopE) || (|inPopL) || outPndngS || outPndngE || outPndngL) bad++;
    end
    checkOutput("nomatch_idle_cycles", bad, 0);

    // Fairness: all four heads to south, downstream always ready
    reset = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(4'b1111, mkPkt(8'hC0, 4'd3, 4'd1, 1'b1, 23'd0), mkPkt(8'hC1, 4'd3, 4'd1, 1'b1, 23'd1),
                  mkPkt(8'hC2, 4'd3, 4'd1, 1'b1, 23'd2), mkPkt(8'hC3, 4'd3, 4'd1, 1'b1, 23'd3));
    outPopS = 1'b1;
    for (int g = 0; g < 12; g++) begin
      tick();
      checkOutput($sformatf("fair_pop_%0d", g), inPopS, 4'b0001 << (g % 4));
      tick();
      checkOutput($sformatf("fair_pndng_%0d", g), outPndngS, 1);
      checkOutput($sformatf("fair_data_%0d", g), outDataS, mkPkt(8'h11, 4'd3, 4'd1, 1'b1, 23'(g % 4)));
      tick();
      checkOutput($sformatf("fair_gap_%0d", g), {inPopS, outPndngS}, 0);
    end

    // Backpressure: hold the packet for 20 cycles, then release once
    outPopS = 1'b0;
    tick();
    checkOutput("bp_pop", inPopS, 4'b0001);
    tick();
    hold = mkPkt(8'h11, 4'd3, 4'd1, 1'b1, 23'd0);
    checkOutput("bp_capture", outDataS, hold);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (outPndngS !== 1'b1 || outDataS !== hold || inPopS !== 4'b0000) bad++;
    end
    checkOutput("bp_stall_cycles", bad, 0);
    outPopS = 1'b1;
    tick();
    checkOutput("bp_release_pndng", outPndngS, 0);
    outPopS = 1'b0;
    checkOutput("bp_release_nopop", inPopS, 0);
    tick();
    checkOutput("bp_next_grant", inPopS, 4'b0010);
    tick();
    checkOutput("bp_next_data", outDataS, mkPkt(8'h11, 4'd3, 4'd1, 1'b1, 23'd1));
    outPopS = 1'b1;
    tick();
    outPopS = 1'b0;

    // Reset during POP and during HOLD
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    checkOutput("rst_pop_pre", inPopS, 4'b0001);
    reset = 1'b1;
    #1;
    checkOutput("rst_pop_cycle", inPopS, 0);
    tick();
    checkOutput("rst_pop_after_pndng", outPndngS, 0);
    checkOutput("rst_pop_after_pop", inPopS, 0);
    reset = 1'b0;
    tick();
    checkOutput("rst_pop_first_grant", inPopS, 4'b0001);
    tick();
    checkOutput("rst_hold_pre", outPndngS, 1);
    reset = 1'b1;
    #1;
    checkOutput("rst_hold_cycle_pop", inPopS, 0);
    tick();
    checkOutput("rst_hold_after_pndng", outPndngS, 0);
    checkOutput("rst_hold_after_data", outDataS, 0);
    reset = 1'b0;
    tick();
    checkOutput("rst_hold_first_grant", inPopS, 4'b0001);
    tick();
    outPopS = 1'b1;
    tick();
    outPopS = 1'b0;
    monitorOn = 1'b0;

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
